// File: rtl/dunit_ctrl.sv
// Debug-unit controller: loads instruction memory from the UART byte stream, runs or
// single-steps the pipeline, then streams all GPRs and the leading data-memory words back out.
module dunit_ctrl #(
  parameter int                 NB_REG        = 32,
  parameter int                 NB_BYTE       = 8,
  parameter int                 NB_IMEM_WORDS = 64,
  parameter int                 NB_DMEM_WORDS = 32,
  parameter logic [NB_REG-1:0]  HALT_WORD     = 32'hFFFF_FFFF
) (
  input  logic               i_clk,
  input  logic               i_reset_n,
  input  logic [NB_BYTE-1:0] i_rx_data,
  input  logic               i_rx_valid,
  output logic [NB_BYTE-1:0] o_tx_data,
  output logic               o_tx_start,
  input  logic               i_tx_done,
  input  logic               i_halt,
  input  logic [NB_REG-1:0]  i_dunit_reg,
  input  logic [NB_REG-1:0]  i_dunit_mem_data,
  output logic               o_dunit_clk_en,
  output logic               o_dunit_reset_pc,
  output logic               o_dunit_w_mem,
  output logic [NB_REG-1:0]  o_dunit_addr,
  output logic [NB_REG-1:0]  o_dunit_data_if,
  output logic               o_busy
);

  localparam int NB_GPR        = 32;
  localparam int NB_DUMP_WORDS = NB_GPR + NB_DMEM_WORDS;
  localparam int NB_WIDX       = $clog2(NB_IMEM_WORDS) + 1;
  localparam int NB_DIDX       = $clog2(NB_DUMP_WORDS) + 1;

  localparam logic [NB_WIDX-1:0] LAST_WIDX = NB_WIDX'(NB_IMEM_WORDS - 1);
  localparam logic [NB_DIDX-1:0] LAST_DIDX = NB_DIDX'(NB_DUMP_WORDS - 1);

  localparam logic [NB_BYTE-1:0] CMD_LOAD = 8'h4C;
  localparam logic [NB_BYTE-1:0] CMD_STEP = 8'h53;
  localparam logic [NB_BYTE-1:0] CMD_RUN  = 8'h43;

  localparam logic [3:0] ST_IDLE      = 4'd0;
  localparam logic [3:0] ST_LOAD      = 4'd1;
  localparam logic [3:0] ST_LOAD_WR   = 4'd2;
  localparam logic [3:0] ST_STEP      = 4'd3;
  localparam logic [3:0] ST_RUN       = 4'd4;
  localparam logic [3:0] ST_DUMP_ADDR = 4'd5;
  localparam logic [3:0] ST_DUMP_CAP  = 4'd6;
  localparam logic [3:0] ST_DUMP_SEND = 4'd7;
  localparam logic [3:0] ST_DUMP_WAIT = 4'd8;

  logic [3:0]         state_r,    state_s;
  logic [NB_WIDX-1:0] word_idx_r, word_idx_s;
  logic [NB_DIDX-1:0] dump_idx_r, dump_idx_s;
  logic [1:0]         byte_cnt_r, byte_cnt_s;
  logic [NB_REG-1:0]  word_r,     word_s;
  logic               clk_en_r,   clk_en_s;
  logic               reset_pc_r, reset_pc_s;
  logic               w_mem_r,    w_mem_s;
  logic [NB_REG-1:0]  addr_r,     addr_s;
  logic [NB_REG-1:0]  data_if_r,  data_if_s;
  logic [NB_BYTE-1:0] tx_data_r,  tx_data_s;
  logic               tx_start_r, tx_start_s;
  logic               busy_r,     busy_s;

  // GPRs are addressed by index, data memory by byte address of the word.
  function automatic logic [NB_REG-1:0] dump_addr(input logic [NB_DIDX-1:0] idx);
    logic [NB_REG-1:0] wide;
    wide = NB_REG'(idx);
    if (idx < NB_DIDX'(NB_GPR)) begin
      dump_addr = wide;
    end else begin
      dump_addr = (wide - NB_REG'(NB_GPR)) << 2'd2;
    end
  endfunction

  function automatic logic [NB_BYTE-1:0] get_byte(input logic [NB_REG-1:0] word,
                                                   input logic [1:0]        sel);
    logic [NB_REG-1:0] shifted;
    shifted  = word << (NB_BYTE * int'(sel));
    get_byte = shifted[NB_REG-1 -: NB_BYTE];
  endfunction

  // Next-state and next-output computation for the whole controller.
  always_comb begin
    state_s    = state_r;
    word_idx_s = word_idx_r;
    dump_idx_s = dump_idx_r;
    byte_cnt_s = byte_cnt_r;
    word_s     = word_r;
    clk_en_s   = clk_en_r;
    reset_pc_s = reset_pc_r;
    w_mem_s    = 1'b0;
    addr_s     = addr_r;
    data_if_s  = data_if_r;
    tx_data_s  = tx_data_r;
    tx_start_s = 1'b0;

    case (state_r)
      ST_IDLE: begin
        if (i_rx_valid) begin
          case (i_rx_data)
            CMD_LOAD: begin
              state_s    = ST_LOAD;
              reset_pc_s = 1'b1;
              word_idx_s = '0;
              byte_cnt_s = 2'd0;
            end
            CMD_STEP: state_s = ST_STEP;
            CMD_RUN:  state_s = ST_RUN;
            default:  state_s = ST_IDLE;
          endcase
        end else begin
          state_s = ST_IDLE;
        end
      end

      ST_LOAD: begin
        if (i_rx_valid) begin
          word_s = {word_r[NB_REG-NB_BYTE-1:0], i_rx_data};
          if (byte_cnt_r == 2'd3) begin
            state_s    = ST_LOAD_WR;
            byte_cnt_s = 2'd0;
            w_mem_s    = 1'b1;
            addr_s     = NB_REG'({word_idx_r, 2'b00});
            data_if_s  = word_s;
          end else begin
            byte_cnt_s = byte_cnt_r + 2'd1;
          end
        end else begin
          state_s = ST_LOAD;
        end
      end

      // The last slot is written even when it is not the halt marker; no wrap-around.
      ST_LOAD_WR: begin
        word_idx_s = word_idx_r + NB_WIDX'(1);
        if ((data_if_r == HALT_WORD) || (word_idx_r == LAST_WIDX)) begin
          state_s    = ST_IDLE;
          reset_pc_s = 1'b0;
        end else begin
          state_s = ST_LOAD;
        end
      end

      ST_STEP: begin
        if (clk_en_r || i_halt) begin
          clk_en_s   = 1'b0;
          state_s    = ST_DUMP_ADDR;
          dump_idx_s = '0;
          byte_cnt_s = 2'd0;
          addr_s     = '0;
        end else begin
          clk_en_s = 1'b1;
        end
      end

      ST_RUN: begin
        if (i_halt) begin
          clk_en_s   = 1'b0;
          state_s    = ST_DUMP_ADDR;
          dump_idx_s = '0;
          byte_cnt_s = 2'd0;
          addr_s     = '0;
        end else begin
          clk_en_s = 1'b1;
        end
      end

      ST_DUMP_ADDR: state_s = ST_DUMP_CAP;

      ST_DUMP_CAP: begin
        if (dump_idx_r < NB_DIDX'(NB_GPR)) begin
          word_s = i_dunit_reg;
        end else begin
          word_s = i_dunit_mem_data;
        end
        tx_data_s  = get_byte(word_s, 2'd0);
        tx_start_s = 1'b1;
        state_s    = ST_DUMP_SEND;
      end

      ST_DUMP_SEND: state_s = ST_DUMP_WAIT;

      ST_DUMP_WAIT: begin
        if (i_tx_done) begin
          if (byte_cnt_r == 2'd3) begin
            byte_cnt_s = 2'd0;
            if (dump_idx_r == LAST_DIDX) begin
              state_s = ST_IDLE;
            end else begin
              dump_idx_s = dump_idx_r + NB_DIDX'(1);
              addr_s     = dump_addr(dump_idx_s);
              state_s    = ST_DUMP_ADDR;
            end
          end else begin
            byte_cnt_s = byte_cnt_r + 2'd1;
            tx_data_s  = get_byte(word_r, byte_cnt_s);
            tx_start_s = 1'b1;
            state_s    = ST_DUMP_SEND;
          end
        end else begin
          state_s = ST_DUMP_WAIT;
        end
      end

      default: begin
        state_s    = ST_IDLE;
        clk_en_s   = 1'b0;
        reset_pc_s = 1'b0;
      end
    endcase

    busy_s = (state_s != ST_IDLE);
  end

  // State and output registers; asynchronous reset aborts any operation in flight.
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      state_r    <= ST_IDLE;
      word_idx_r <= '0;
      dump_idx_r <= '0;
      byte_cnt_r <= 2'd0;
      word_r     <= '0;
      clk_en_r   <= 1'b0;
      reset_pc_r <= 1'b0;
      w_mem_r    <= 1'b0;
      addr_r     <= '0;
      data_if_r  <= '0;
      tx_data_r  <= '0;
      tx_start_r <= 1'b0;
      busy_r     <= 1'b0;
    end else begin
      state_r    <= state_s;
      word_idx_r <= word_idx_s;
      dump_idx_r <= dump_idx_s;
      byte_cnt_r <= byte_cnt_s;
      word_r     <= word_s;
      clk_en_r   <= clk_en_s;
      reset_pc_r <= reset_pc_s;
      w_mem_r    <= w_mem_s;
      addr_r     <= addr_s;
      data_if_r  <= data_if_s;
      tx_data_r  <= tx_data_s;
      tx_start_r <= tx_start_s;
      busy_r     <= busy_s;
    end
  end

  assign o_tx_data        = tx_data_r;
  assign o_tx_start       = tx_start_r;
  assign o_dunit_clk_en   = clk_en_r;
  assign o_dunit_reset_pc = reset_pc_r;
  assign o_dunit_w_mem    = w_mem_r;
  assign o_dunit_addr     = addr_r;
  assign o_dunit_data_if  = data_if_r;
  assign o_busy           = busy_r;

endmodule

// File: tb/tb_dunit_ctrl.sv
// Self-checking bench for dunit_ctrl: directed UART commands against a queue-based model
// of the expected instruction writes and dump byte stream.
module tb_dunit_ctrl;
  localparam int NB_REG     = 32;
  localparam int NB_BYTE    = 8;
  localparam int IMEM_WORDS = 4;
  localparam int DMEM_WORDS = 32;
  localparam int DUMP_BYTES = 4 * (32 + DMEM_WORDS);

  logic               i_clk = 1'b0;
  logic               i_reset_n;
  logic [NB_BYTE-1:0] i_rx_data;
  logic               i_rx_valid;
  logic [NB_BYTE-1:0] o_tx_data;
  logic               o_tx_start;
  logic               i_tx_done;
  logic               i_halt;
  logic [NB_REG-1:0]  i_dunit_reg;
  logic [NB_REG-1:0]  i_dunit_mem_data;
  logic               o_dunit_clk_en;
  logic               o_dunit_reset_pc;
  logic               o_dunit_w_mem;
  logic [NB_REG-1:0]  o_dunit_addr;
  logic [NB_REG-1:0]  o_dunit_data_if;
  logic               o_busy;

  always #5 i_clk = ~i_clk;

  dunit_ctrl #(
    .NB_REG(NB_REG), .NB_BYTE(NB_BYTE), .NB_IMEM_WORDS(IMEM_WORDS),
    .NB_DMEM_WORDS(DMEM_WORDS), .HALT_WORD(32'hFFFF_FFFF)
  ) dut (
    .i_clk(i_clk), .i_reset_n(i_reset_n), .i_rx_data(i_rx_data), .i_rx_valid(i_rx_valid),
    .o_tx_data(o_tx_data), .o_tx_start(o_tx_start), .i_tx_done(i_tx_done), .i_halt(i_halt),
    .i_dunit_reg(i_dunit_reg), .i_dunit_mem_data(i_dunit_mem_data),
    .o_dunit_clk_en(o_dunit_clk_en), .o_dunit_reset_pc(o_dunit_reset_pc),
    .o_dunit_w_mem(o_dunit_w_mem), .o_dunit_addr(o_dunit_addr),
    .o_dunit_data_if(o_dunit_data_if), .o_busy(o_busy)
  );

  // Pipeline stand-ins: read data is a fixed function of the address presented.
  function automatic logic [31:0] regf(input logic [4:0] a);
    return 32'h1122_3344 ^ ({27'd0, a} * 32'h0102_0304);
  endfunction
  function automatic logic [31:0] memf(input logic [31:0] a);
    return 32'hC0DE_0000 + a;
  endfunction
  assign i_dunit_reg      = regf(o_dunit_addr[4:0]);
  assign i_dunit_mem_data = memf(o_dunit_addr);

  typedef struct { logic [31:0] addr; logic [31:0] data; } wr_t;
  wr_t          exp_wr[$];
  logic [7:0]   exp_tx[$];
  logic [7:0]   got_tx[$];
  logic [31:0]  load_words[$];
  int n_checks = 0, n_errors = 0;
  int clk_en_cnt = 0, w_cnt = 0, act_cnt = 0;
  int resp_delay = 3;
  bit stray_en = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic fail(input string name, input string why);
    n_checks++;
    n_errors++;
    $display("FAIL %s: %s", name, why);
  endtask

  // Expected imem writes: word i lands at i*4, stops after the halt marker or a full memory.
  task automatic model_load();
    for (int i = 0; i < load_words.size(); i++) begin
      if (i >= IMEM_WORDS) break;
      exp_wr.push_back('{addr: 32'(i) * 32'd4, data: load_words[i]});
      if (load_words[i] == 32'hFFFF_FFFF) break;
    end
  endtask

  task automatic model_dump();
    logic [31:0] v;
    for (int w = 0; w < 32 + DMEM_WORDS; w++) begin
      v = (w < 32) ? regf(5'(w)) : memf(32'((w - 32) * 4));
      for (int b = 3; b >= 0; b--) exp_tx.push_back(v[b*8 +: 8]);
    end
  endtask

  task automatic send_byte(input logic [7:0] b, input int gap);
    @(negedge i_clk);
    i_rx_data  = b;
    i_rx_valid = 1'b1;
    @(negedge i_clk);
    i_rx_valid = 1'b0;
    repeat (gap) @(negedge i_clk);
  endtask

  task automatic send_word(input logic [31:0] w);
    for (int b = 3; b >= 0; b--) send_byte(w[b*8 +: 8], 3);
  endtask

  task automatic wait_idle(input string name, input int limit);
    int n = 0;
    while (o_busy && n < limit) begin
      @(negedge i_clk);
      n++;
    end
    if (o_busy) fail(name, "timeout waiting for o_busy to fall");
    else chk(name, 32'(o_busy), 32'd0);
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_tx_data"},  32'(o_tx_data), 32'd0);
    chk({tag, "_tx_start"}, 32'(o_tx_start), 32'd0);
    chk({tag, "_clk_en"},   32'(o_dunit_clk_en), 32'd0);
    chk({tag, "_reset_pc"}, 32'(o_dunit_reset_pc), 32'd0);
    chk({tag, "_w_mem"},    32'(o_dunit_w_mem), 32'd0);
    chk({tag, "_addr"},     o_dunit_addr, 32'd0);
    chk({tag, "_data_if"},  o_dunit_data_if, 32'd0);
    chk({tag, "_busy"},     32'(o_busy), 32'd0);
  endtask

  task automatic chk_dump(input string tag, input int exp_en);
    chk({tag, "_clk_en_cycles"}, 32'(clk_en_cnt), 32'(exp_en));
    chk({tag, "_byte_count"}, 32'(got_tx.size()), 32'(DUMP_BYTES));
    chk({tag, "_model_left"}, 32'(exp_tx.size()), 32'd0);
  endtask

  // Transmitter stand-in: done after resp_delay cycles, optional stray done two cycles later.
  initial begin
    int ack_t = 0, stray_t = 0, starts = 0;
    i_tx_done = 1'b0;
    forever begin
      @(negedge i_clk);
      i_tx_done = 1'b0;
      if (ack_t > 0) begin
        ack_t--;
        if (ack_t == 0) begin
          i_tx_done = 1'b1;
          if (stray_en && (starts % 4 == 0)) stray_t = 2;
        end
      end else if (stray_t > 0) begin
        stray_t--;
        if (stray_t == 0) i_tx_done = 1'b1;
      end
      if (o_tx_start) begin
        starts++;
        ack_t = resp_delay;
      end
    end
  end

  // Per-cycle comparison of DUT outputs against the model queues.
  initial begin
    wr_t e;
    logic [7:0] eb;
    forever begin
      @(negedge i_clk);
      if (i_reset_n) begin
        if (o_dunit_w_mem) begin
          w_cnt++;
          chk("w_mem_reset_pc", 32'(o_dunit_reset_pc), 32'd1);
          if (exp_wr.size() == 0) begin
            fail("unexpected_write", $sformatf("addr 0x%08h data 0x%08h", o_dunit_addr, o_dunit_data_if));
          end else begin
            e = exp_wr.pop_front();
            chk("w_mem_addr", o_dunit_addr, e.addr);
            chk("w_mem_data", o_dunit_data_if, e.data);
          end
        end
        if (o_tx_start) begin
          got_tx.push_back(o_tx_data);
          if (exp_tx.size() == 0) begin
            fail("unexpected_tx", $sformatf("byte 0x%02h", o_tx_data));
          end else begin
            eb = exp_tx.pop_front();
            chk($sformatf("tx_byte[%0d]", got_tx.size() - 1), 32'(o_tx_data), 32'(eb));
          end
        end
        if (o_dunit_clk_en) clk_en_cnt++;
        if (o_busy || o_dunit_w_mem || o_tx_start || o_dunit_clk_en || o_dunit_reset_pc) act_cnt++;
        if (o_dunit_w_mem || o_tx_start || o_dunit_clk_en || o_dunit_reset_pc)
          chk("busy_when_active", 32'(o_busy), 32'd1);
        chk("clk_en_and_reset_pc", 32'(o_dunit_clk_en & o_dunit_reset_pc), 32'd0);
      end
    end
  end

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    i_reset_n  = 1'b0;
    i_rx_data  = 8'h00;
    i_rx_valid = 1'b0;
    i_halt     = 1'b0;
    #12;
    chk_all_zero("reset");
    repeat (2) @(negedge i_clk);
    i_reset_n = 1'b1;
    repeat (2) @(negedge i_clk);

    // Unknown command byte is ignored
    act_cnt = 0;
    send_byte(8'h41, 10);
    chk("ignored_byte_activity", 32'(act_cnt), 32'd0);

    // Program load terminated by the halt marker
    load_words = '{32'h2006_000B, 32'h0800_0010, 32'hFFFF_FFFF};
    model_load();
    chk("model_load_count", 32'(exp_wr.size()), 32'd3);
    chk("model_load_addr2", exp_wr[2].addr, 32'd8);
    w_cnt = 0;
    clk_en_cnt = 0;
    send_byte(8'h4C, 3);
    chk("load_reset_pc_on_entry", 32'(o_dunit_reset_pc), 32'd1);
    chk("load_busy", 32'(o_busy), 32'd1);
    foreach (load_words[i]) send_word(load_words[i]);
    chk("load_write_count", 32'(w_cnt), 32'd3);
    chk("load_model_left", 32'(exp_wr.size()), 32'd0);
    chk("load_reset_pc_after", 32'(o_dunit_reset_pc), 32'd0);
    chk("load_busy_after", 32'(o_busy), 32'd0);
    chk("load_clk_en", 32'(clk_en_cnt), 32'd0);

    // Single step with slow transmitter and stray done pulses
    resp_delay = 20;
    stray_en   = 1'b1;
    got_tx.delete();
    clk_en_cnt = 0;
    model_dump();
    chk("model_dump_size", 32'(exp_tx.size()), 32'(DUMP_BYTES));
    chk("model_dump_b0", 32'(exp_tx[0]), 32'h11);
    chk("model_dump_b128", 32'(exp_tx[128]), 32'hC0);
    send_byte(8'h53, 3);
    wait_idle("step_idle", 20000);
    chk_dump("step", 1);
    chk("step_b0", 32'(got_tx[0]), 32'h11);
    chk("step_b1", 32'(got_tx[1]), 32'h22);
    chk("step_b2", 32'(got_tx[2]), 32'h33);
    chk("step_b3", 32'(got_tx[3]), 32'h44);
    chk("step_b128", 32'(got_tx[128]), 32'hC0);
    chk("step_b129", 32'(got_tx[129]), 32'hDE);
    chk("step_b130", 32'(got_tx[130]), 32'h00);
    chk("step_b131", 32'(got_tx[131]), 32'h00);
    chk("step_b7", 32'(got_tx[7]), 32'h40);

    // Continuous run, halt raised after 7 enabled cycles
    resp_delay = 3;
    stray_en   = 1'b0;
    got_tx.delete();
    clk_en_cnt = 0;
    model_dump();
    send_byte(8'h43, 0);
    n = 0;
    while (!o_dunit_clk_en && n < 20) begin
      @(negedge i_clk);
      n++;
    end
    if (!o_dunit_clk_en) fail("run_clk_en_rise", "clk_en never rose");
    repeat (6) @(negedge i_clk);
    i_halt = 1'b1;
    wait_idle("run_idle", 20000);
    chk_dump("run", 7);

    // Run with halt already asserted: dump only
    got_tx.delete();
    clk_en_cnt = 0;
    model_dump();
    send_byte(8'h43, 3);
    wait_idle("run_halted_idle", 20000);
    chk_dump("run_halted", 0);
    i_halt = 1'b0;

    // Asynchronous reset in the middle of a dump, then a complete dump
    got_tx.delete();
    model_dump();
    send_byte(8'h53, 3);
    n = 0;
    while (got_tx.size() < 37 && n < 5000) begin
      @(negedge i_clk);
      n++;
    end
    if (got_tx.size() < 37) fail("reset_mid_dump_reach", "dump never reached byte 37");
    #2 i_reset_n = 1'b0;
    #1 chk_all_zero("mid_reset");
    exp_tx.delete();
    repeat (3) @(negedge i_clk);
    i_reset_n = 1'b1;
    repeat (40) @(negedge i_clk);
    got_tx.delete();
    clk_en_cnt = 0;
    model_dump();
    send_byte(8'h53, 3);
    wait_idle("post_reset_idle", 20000);
    chk_dump("post_reset", 1);

    // Load overflow without halt marker: only IMEM_WORDS writes, rest ignored in IDLE
    load_words = '{32'h0102_0304, 32'h0506_0708, 32'h090A_0B0C,
                   32'h0D0E_0F10, 32'h1112_1314, 32'h1516_1718};
    exp_wr.delete();
    model_load();
    chk("model_ovf_count", 32'(exp_wr.size()), 32'd4);
    chk("model_ovf_last_addr", exp_wr[3].addr, 32'd12);
    w_cnt = 0;
    got_tx.delete();
    send_byte(8'h4C, 3);
    foreach (load_words[i]) send_word(load_words[i]);
    repeat (5) @(negedge i_clk);
    chk("ovf_write_count", 32'(w_cnt), 32'd4);
    chk("ovf_model_left", 32'(exp_wr.size()), 32'd0);
    chk("ovf_busy", 32'(o_busy), 32'd0);
    chk("ovf_reset_pc", 32'(o_dunit_reset_pc), 32'd0);
    chk("ovf_no_tx", 32'(got_tx.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
